// File: rtl/crossbar_pkg.sv
// Shared constants and helpers for the crossbar arbiter and its per-output arbiters.
package crossbar_pkg;
  localparam int DEF_N_PORTS = 8;
  localparam int DEF_WIDTH   = 320;
  localparam int DEF_CNT_W   = 32;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for one output: searches from ptr upward, one-hot grant,
// pointer advances past the winner only when a grant is issued.
module rr_arbiter
  import crossbar_pkg::*;
#(
  parameter int N     = DEF_N_PORTS,
  localparam int SEL_W = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);
  logic [SEL_W-1:0] ptr, ptr_nxt, idx;
  logic             found;

  // N is a power of two, so SEL_W-bit arithmetic wraps modulo N for free.
  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr + SEL_W'(k);
      if (!found && en && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_nxt    = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr <= '0;
    else if (found) ptr <= ptr_nxt;
  end
endmodule

// File: rtl/crossbar_arb.sv
// N x N crossbar: per-output round-robin arbitration into a one-entry output
// register, with a saturating count of cycles where any valid input was refused.
module crossbar_arb
  import crossbar_pkg::*;
#(
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int CNT_W   = DEF_CNT_W,
  localparam int SEL_W  = clog2(N_PORTS)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_PORTS-1:0]                in_valid,
  input  logic [N_PORTS-1:0][SEL_W-1:0]     in_dest,
  input  logic [N_PORTS-1:0][WIDTH-1:0]     in_data,
  output logic [N_PORTS-1:0]                in_ready,
  output logic [N_PORTS-1:0]                out_valid,
  output logic [N_PORTS-1:0][WIDTH-1:0]     out_data,
  output logic [N_PORTS-1:0][SEL_W-1:0]     out_src,
  input  logic [N_PORTS-1:0]                out_ready,
  output logic [CNT_W-1:0]                  stall_cnt
);
  logic [N_PORTS-1:0][N_PORTS-1:0] req, grant;
  logic [N_PORTS-1:0]              can_load;

  always_comb begin
    req = '0;
    for (int j = 0; j < N_PORTS; j++)
      for (int i = 0; i < N_PORTS; i++)
        req[j][i] = in_valid[i] && (in_dest[i] == SEL_W'(j));
  end

  // Each input targets exactly one output, so OR-ing grants never double-accepts.
  always_comb begin
    in_ready = '0;
    for (int j = 0; j < N_PORTS; j++)
      for (int i = 0; i < N_PORTS; i++)
        if (grant[j][i]) in_ready[i] = 1'b1;
  end

  for (genvar j = 0; j < N_PORTS; j++) begin : g_out
    logic [SEL_W-1:0] sel;
    logic             vld;
    logic [WIDTH-1:0] dat;
    logic [SEL_W-1:0] src;

    // rst gates the arbiter enable so in_ready is low throughout reset.
    assign can_load[j] = (!vld || out_ready[j]) && !rst;

    rr_arbiter #(.N(N_PORTS)) u_arb (
      .clk   (clk),
      .rst   (rst),
      .req   (req[j]),
      .en    (can_load[j]),
      .grant (grant[j])
    );

    always_comb begin
      sel = '0;
      for (int i = 0; i < N_PORTS; i++)
        if (grant[j][i]) sel = SEL_W'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld <= 1'b0;
        dat <= '0;
        src <= '0;
      end else if (|grant[j]) begin
        vld <= 1'b1;
        dat <= in_data[sel];
        src <= sel;
      end else if (out_ready[j]) begin
        vld <= 1'b0;
      end
    end

    assign out_valid[j] = vld;
    assign out_data[j]  = dat;
    assign out_src[j]   = src;
  end

  logic stall;
  assign stall = |(in_valid & ~in_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stall_cnt <= '0;
    else if (stall && ~&stall_cnt)    stall_cnt <= stall_cnt + 1'b1;
  end
endmodule
